half_subtractor: RTL and testbench
==================================

HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Interface
REQ-001 Parameter CNT_W, default 16: width of the borrow-event counter.
REQ-002 Port clk, input, 1: single clock; all sequential logic on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port a, input, 1: minuend bit.
REQ-005 Port b, input, 1: subtrahend bit.
REQ-006 Port in_valid, input, 1: qualifies a/b for the registered path and the counter.
REQ-007 Port clr_cnt, input, 1: synchronous clear of borrow_cnt.
REQ-008 Port d, output, 1: combinational difference, a XOR b.
REQ-009 Port borrow, output, 1: combinational borrow, (NOT a) AND b.
REQ-010 Port d_q, output, 1: registered difference.
REQ-011 Port borrow_q, output, 1: registered borrow.
REQ-012 Port out_valid, output, 1: registered in_valid.
REQ-013 Port borrow_cnt, output, CNT_W: count of valid borrow events, saturating.

Function
REQ-014 d and borrow SHALL depend only on a and b, with zero clock latency, and SHALL be independent of clk, rst_n, in_valid and clr_cnt.
REQ-015 Combinational truth table (a,b -> d,borrow): 00->0,0; 01->1,1; 10->1,0; 11->0,0.
REQ-016 On each rising clk edge with in_valid=1, d_q and borrow_q SHALL load the current d and borrow, giving 1-cycle latency.
REQ-017 On a rising edge with in_valid=0, d_q and borrow_q SHALL hold their previous values.
REQ-018 out_valid SHALL equal in_valid delayed by one clock, every cycle.
REQ-019 borrow_cnt SHALL increment by 1 on a rising edge when in_valid=1 and borrow=1.
REQ-020 borrow_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 clr_cnt=1 SHALL set borrow_cnt to 0 on the next edge; clr_cnt takes priority over a simultaneous increment.
REQ-022 clr_cnt SHALL NOT affect d_q, borrow_q or out_valid.
REQ-023 X/Z on a or b SHALL NOT be masked; the outputs follow standard gate semantics.

Reset
REQ-024 While rst_n=0, d_q, borrow_q and out_valid SHALL be 0 and borrow_cnt SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-025 Combinational d and borrow SHALL remain functional during reset.
REQ-026 After rst_n deasserts, the first rising edge SHALL operate normally. An operation that reset interrupts is discarded, and its count is not recorded.

Verification
REQ-027 Exhaustive combinational check, no clock required: hold rst_n=0, a toggles every 400 ns and b every 200 ns, both starting at 0, run 800 ns. Expected (d,borrow): 0-200 ns 0,0; 200-400 ns 1,1; 400-600 ns 1,0; 600-800 ns 0,0.
REQ-028 Registered path: in_valid=1 with a=0,b=1 at edge N. Expected: d_q=1, borrow_q=1, out_valid=1 after edge N. Then in_valid=0 with a=1,b=0 at edge N+1. Expected: d_q=1, borrow_q=1 held, out_valid=0.
REQ-029 Counter: apply 5 valid cycles of a=0,b=1 interleaved with 3 valid cycles of a=1,b=1. Expected: borrow_cnt=5.
REQ-030 Saturation, CNT_W=2: apply 6 valid borrow cycles. Expected: borrow_cnt=3.
REQ-031 Clear priority: assert clr_cnt together with a valid borrow cycle while borrow_cnt=4. Expected: borrow_cnt=0 after the edge.
REQ-032 Async reset: drop rst_n mid-cycle while d_q=1 and borrow_cnt=7. Expected: d_q, borrow_q, out_valid and borrow_cnt are 0 before the next edge, and d/borrow still track a/b.

Source files
------------

// File: rtl/half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
//
// One-bit half subtractor with a registered copy of its result and a
// saturating counter of qualified borrow events.
//
// The combinational outputs d/borrow are pure gate functions of a/b. They
// ignore clk, reset and the control inputs, and X/Z on a or b propagate
// through them unmasked. The registered path captures d/borrow only on
// in_valid cycles and holds otherwise. out_valid is in_valid delayed by
// one clock.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears all state)
//   a          in   minuend bit
//   b          in   subtrahend bit
//   in_valid   in   qualifies a/b for the registered path and the counter
//   clr_cnt    in   synchronous clear of borrow_cnt (wins over increment)
//   d          out  combinational difference, a ^ b
//   borrow     out  combinational borrow, ~a & b
//   d_q        out  registered difference
//   borrow_q   out  registered borrow
//   out_valid  out  in_valid delayed by one clock
//   borrow_cnt out  saturating count of valid borrow events
// -----------------------------------------------------------------------------
module half_subtractor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             d,
    output logic             borrow,
    output logic             d_q,
    output logic             borrow_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             d_d;
    logic             borrow_d;
    logic             out_valid_d;
    logic             out_valid_q;
    logic [CNT_W-1:0] borrow_cnt_d;
    logic [CNT_W-1:0] borrow_cnt_q;

    // Gate-level difference and borrow; no masking so X/Z stays visible.
    always_comb begin
        d      = a ^ b;
        borrow = ~a & b;
    end

    always_comb begin
        d_d          = d_q;
        borrow_d     = borrow_q;
        out_valid_d  = in_valid;
        borrow_cnt_d = borrow_cnt_q;

        if (in_valid) begin
            d_d      = d;
            borrow_d = borrow;
        end

        // Clear has priority; otherwise count qualified borrows, sticking at max.
        if (clr_cnt) begin
            borrow_cnt_d = '0;
        end else if (in_valid && borrow && (borrow_cnt_q != CNT_MAX)) begin
            borrow_cnt_d = borrow_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q          <= 1'b0;
            borrow_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            borrow_cnt_q <= '0;
        end else begin
            d_q          <= d_d;
            borrow_q     <= borrow_d;
            out_valid_q  <= out_valid_d;
            borrow_cnt_q <= borrow_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign borrow_cnt = borrow_cnt_q;

endmodule

// File: tb/tb_half_subtractor.sv
// -----------------------------------------------------------------------------
// tb_half_subtractor
//
// Drives two instances of half_subtractor from shared stimulus: one with the
// default 16-bit counter and one with a 2-bit counter to exercise
// saturation. Expected register/counter values come from a small behavioural
// model, pushed to a scoreboard queue when a step is driven and popped after
// the clock edge that produces them.
// -----------------------------------------------------------------------------
module tb_half_subtractor;

    typedef struct {
        logic        d;
        logic        b;
        logic        v;
        logic [15:0] c16;
        logic [1:0]  c2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        in_valid;
    logic        clr_cnt;

    logic        d, borrow, d_q, borrow_q, out_valid;
    logic [15:0] borrow_cnt;
    logic        s_d, s_borrow, s_d_q, s_borrow_q, s_out_valid;
    logic [1:0]  s_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    exp_t sb[$];

    logic        m_d, m_b, m_v;
    logic [15:0] m_c16;
    logic [1:0]  m_c2;

    half_subtractor #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .clr_cnt(clr_cnt), .d(d), .borrow(borrow), .d_q(d_q),
        .borrow_q(borrow_q), .out_valid(out_valid), .borrow_cnt(borrow_cnt)
    );

    half_subtractor #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .clr_cnt(clr_cnt), .d(s_d), .borrow(s_borrow), .d_q(s_d_q),
        .borrow_q(s_borrow_q), .out_valid(s_out_valid), .borrow_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d = 1'b0; m_b = 1'b0; m_v = 1'b0; m_c16 = '0; m_c2 = '0;
    endtask

    // One clock of stimulus: drive after the falling edge, predict, then
    // compare both instances just after the rising edge.
    task automatic step(input logic ia, input logic ib, input logic iv, input logic ic);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; in_valid = iv; clr_cnt = ic;
        if (iv) begin
            m_d = ia ^ ib;
            m_b = ~ia & ib;
        end
        m_v = iv;
        if (ic) begin
            m_c16 = '0;
            m_c2  = '0;
        end else if (iv && !ia && ib) begin
            if (m_c16 != 16'hFFFF) m_c16 = m_c16 + 16'd1;
            if (m_c2 != 2'b11)     m_c2  = m_c2 + 2'd1;
        end
        e = '{m_d, m_b, m_v, m_c16, m_c2};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("d_q",        {15'd0, d_q},         {15'd0, e.d});
        chk("borrow_q",   {15'd0, borrow_q},    {15'd0, e.b});
        chk("out_valid",  {15'd0, out_valid},   {15'd0, e.v});
        chk("borrow_cnt", borrow_cnt,           e.c16);
        chk("sat_d_q",    {15'd0, s_d_q},       {15'd0, e.d});
        chk("sat_cnt",    {14'd0, s_cnt},       {14'd0, e.c2});
    endtask

    task automatic chk_comb(input string tag, input logic ed, input logic eb);
        chk({tag, "_d"},          {15'd0, d},        {15'd0, ed});
        chk({tag, "_borrow"},     {15'd0, borrow},   {15'd0, eb});
        chk({tag, "_sat_d"},      {15'd0, s_d},      {15'd0, ed});
        chk({tag, "_sat_borrow"}, {15'd0, s_borrow}, {15'd0, eb});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_d_q"},       {15'd0, d_q},         16'd0);
        chk({tag, "_borrow_q"},  {15'd0, borrow_q},    16'd0);
        chk({tag, "_out_valid"}, {15'd0, out_valid},   16'd0);
        chk({tag, "_cnt"},       borrow_cnt,           16'd0);
        chk({tag, "_sat_cnt"},   {14'd0, s_cnt},       16'd0);
        chk({tag, "_sat_ov"},    {15'd0, s_out_valid}, 16'd0);
        chk({tag, "_sat_bq"},    {15'd0, s_borrow_q},  16'd0);
    endtask

    initial begin
        // Exhaustive truth table under reset: b toggles every 200, a every 400.
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; a = 1'b0; b = 1'b0;
        model_reset();
        #100; chk_comb("tt00", 1'b0, 1'b0); chk_reset_state("rst");
        #100; b = 1'b1;
        #100; chk_comb("tt01", 1'b1, 1'b1);
        #100; a = 1'b1; b = 1'b0;
        #100; chk_comb("tt10", 1'b1, 1'b0);
        #100; b = 1'b1;
        #100; chk_comb("tt11", 1'b0, 1'b0);
        #100;

        // X on an input is not masked by the gate functions.
        a = 1'bx; b = 1'b0; #1; chk_comb("x_a", 1'bx, 1'b0);
        a = 1'b0; b = 1'bx; #1; chk_comb("x_b", 1'bx, 1'bx);
        a = 1'b0; b = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;

        // Registered path: load on valid, hold on invalid.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rp_load_d_q", {15'd0, d_q}, 16'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rp_hold_borrow_q", {15'd0, borrow_q}, 16'd1);
        chk("rp_hold_ov", {15'd0, out_valid}, 16'd0);

        // Counter: 5 borrows interleaved with 3 valid non-borrow cycles,
        // plus an invalid borrow that must not count.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("cnt_five", borrow_cnt, 16'd5);

        // Saturation of the 2-bit counter over 6 borrows.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_three", {14'd0, s_cnt}, 16'd3);
        chk("cnt_six", borrow_cnt, 16'd6);

        // Clear beats a simultaneous valid borrow.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_clr_four", borrow_cnt, 16'd4);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_priority", borrow_cnt, 16'd0);
        chk("clr_ov_kept", {15'd0, out_valid}, 16'd1);

        // Reach d_q=1, cnt=7, then drop reset mid-cycle.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_cnt", borrow_cnt, 16'd7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_state("async");
        a = 1'b1; b = 1'b1; #1; chk_comb("rst_tt11", 1'b0, 1'b0);
        a = 1'b0; b = 1'b1; in_valid = 1'b1; #1; chk_comb("rst_tt01", 1'b1, 1'b1);

        // A valid borrow across an edge while in reset is discarded.
        @(posedge clk); #1;
        chk_reset_state("rst_edge");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        // First cycles after release behave normally.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_cnt", borrow_cnt, 16'd1);

        if (n_fail != 0) $display("%0d comparison(s) above did not match", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
